// File: rtl/dst_sel_pipe_pkg.sv
// dst_sel_pipe_pkg: shared constants for destination-register selection.
//   REGDST_* : encodings of the decoder's regdst field
//   ADDR_W_DEF, RA_ADDR_DEF : default register-address width and link register
package dst_sel_pipe_pkg;
  typedef logic [1:0] regdst_t;

  localparam regdst_t REGDST_RT   = 2'b00;
  localparam regdst_t REGDST_RD   = 2'b01;
  localparam regdst_t REGDST_RA   = 2'b10;
  localparam regdst_t REGDST_NONE = 2'b11;

  localparam int ADDR_W_DEF  = 5;
  localparam int RA_ADDR_DEF = 31;
endpackage

// File: rtl/dst_sel_pipe_stage_reg.sv
// dst_stage_reg: one {dst, we} pipeline slot.
//   clk, rst_n     : clock, async active-low reset (clears slot)
//   clear          : load {0,0}; wins over load/hold
//   load           : capture d_dst/d_we; otherwise hold
//   d_dst, d_we    : next-slot data
//   q_dst, q_we    : registered slot
module dst_stage_reg #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] d_dst,
  input  logic              d_we,
  output logic [ADDR_W-1:0] q_dst,
  output logic              q_we
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_dst <= '0;
      q_we  <= 1'b0;
    end else if (clear) begin
      q_dst <= '0;
      q_we  <= 1'b0;
    end else if (load) begin
      q_dst <= d_dst;
      q_we  <= d_we;
    end
  end
endmodule

// File: rtl/dst_sel_pipe.sv
// dst_sel_pipe: picks the write-back destination (rt / rd / link / none) and
// carries {dst, we} through STAGES slots, exposing every slot for forwarding.
//   clk, rst_n            : clock, async active-low reset
//   rt_i, rd_i, regdst_i  : decoded fields and destination mode
//   regwrite_i, valid_i   : write intent and slot-valid
//   stall_i, flush_i      : freeze whole pipe / kill the stage-0 load
//   src_a_i, src_b_i      : decode-stage sources for hazard compare
//   dst_o, we_o           : per-stage dst (stage k at [k*ADDR_W +: ADDR_W]) / we
//   wb_dst_o, wb_we_o     : last stage, to the register file
//   hit_a_o, hit_b_o      : stage k writes src_a_i / src_b_i
// Build option: define DST_SEL_PIPE_HAZARD_EN to generate the hazard compares;
// otherwise hit_* are tied low and src_* are ignored.
module dst_sel_pipe
  import dst_sel_pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int STAGES  = 3,
  parameter int RA_ADDR = RA_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        rt_i,
  input  logic [ADDR_W-1:0]        rd_i,
  input  logic [1:0]               regdst_i,
  input  logic                     regwrite_i,
  input  logic                     valid_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        src_a_i,
  input  logic [ADDR_W-1:0]        src_b_i,
  output logic [STAGES*ADDR_W-1:0] dst_o,
  output logic [STAGES-1:0]        we_o,
  output logic [ADDR_W-1:0]        wb_dst_o,
  output logic                     wb_we_o,
  output logic [STAGES-1:0]        hit_a_o,
  output logic [STAGES-1:0]        hit_b_o
);
  logic [ADDR_W-1:0]             sel;
  logic                          eff_we;
  logic [STAGES-1:0][ADDR_W-1:0] dst_q;
  logic [STAGES-1:0]             we_q;

  always_comb begin
    sel = '0;
    case (regdst_i)
      REGDST_RT: sel = rt_i;
      REGDST_RD: sel = rd_i;
      REGDST_RA: sel = ADDR_W'(RA_ADDR);
      default:   sel = '0;
    endcase
  end

  // r0 is hardwired, so a write to it is dropped here rather than at the RF.
  assign eff_we = valid_i & regwrite_i & (regdst_i != REGDST_NONE) & (|sel);

  // Flush clears only stage 0; later stages still obey stall.
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      if (k == 0) begin : g_head
        dst_stage_reg #(.ADDR_W(ADDR_W)) u_stg (
          .clk(clk), .rst_n(rst_n), .clear(flush_i), .load(~stall_i),
          .d_dst(sel), .d_we(eff_we), .q_dst(dst_q[0]), .q_we(we_q[0]));
      end else begin : g_tail
        dst_stage_reg #(.ADDR_W(ADDR_W)) u_stg (
          .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(~stall_i),
          .d_dst(dst_q[k-1]), .d_we(we_q[k-1]), .q_dst(dst_q[k]), .q_we(we_q[k]));
      end
    end
  endgenerate

  assign dst_o    = dst_q;
  assign we_o     = we_q;
  assign wb_dst_o = dst_q[STAGES-1];
  assign wb_we_o  = we_q[STAGES-1];

`ifdef DST_SEL_PIPE_HAZARD_EN
  generate
    for (k = 0; k < STAGES; k++) begin : g_hz
      assign hit_a_o[k] = we_q[k] & (dst_q[k] == src_a_i) & (|src_a_i);
      assign hit_b_o[k] = we_q[k] & (dst_q[k] == src_b_i) & (|src_b_i);
    end
  endgenerate
`else
  logic unused_src;
  assign unused_src = ^{src_a_i, src_b_i};
  assign hit_a_o = '0;
  assign hit_b_o = '0;
`endif
endmodule

// File: tb/tb_dst_sel_pipe.sv
module tb_dst_sel_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rt_i, rd_i, src_a_i, src_b_i;
  logic [1:0]  regdst_i;
  logic        regwrite_i, valid_i, stall_i, flush_i;
  logic [14:0] dst_o;
  logic [2:0]  we_o, hit_a_o, hit_b_o;
  logic [4:0]  wb_dst_o;
  logic        wb_we_o;

`ifdef DST_SEL_PIPE_HAZARD_EN
  localparam logic [2:0] HZ_S1 = 3'b010;
`else
  localparam logic [2:0] HZ_S1 = 3'b000;
`endif

  dst_sel_pipe dut (
    .clk(clk), .rst_n(rst_n), .rt_i(rt_i), .rd_i(rd_i), .regdst_i(regdst_i),
    .regwrite_i(regwrite_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .dst_o(dst_o), .we_o(we_o),
    .wb_dst_o(wb_dst_o), .wb_we_o(wb_we_o), .hit_a_o(hit_a_o), .hit_b_o(hit_b_o));

  always #5 clk = ~clk;

  typedef struct { logic [4:0] dst; int cyc; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic stall_d;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) stall_d <= 1'b0; else stall_d <= stall_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: each new entry presented with wb_we_o high is popped and compared.
  always @(negedge clk) begin
    if (rst_n && wb_we_o && !stall_d) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got dst %0d at cycle %0d expected no write", wb_dst_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_dst", 32'(wb_dst_o), 32'(e.dst));
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [4:0] d, input int lat);
    exp_t e;
    e.dst = d; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic step(input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] rdst,
                      input logic rw, input logic v, input logic st, input logic fl);
    rt_i = rt; rd_i = rd; regdst_i = rdst; regwrite_i = rw;
    valid_i = v; stall_i = st; flush_i = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; rt_i = '0; rd_i = '0; regdst_i = '0; regwrite_i = 0;
    valid_i = 0; stall_i = 0; flush_i = 0; src_a_i = '0; src_b_i = '0;
    #12;
    chk("rst_dst", 32'(dst_o), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_wb_dst", 32'(wb_dst_o), 0);
    chk("rst_wb_we", 32'(wb_we_o), 0);
    chk("rst_hit_a", 32'(hit_a_o), 0);
    chk("rst_hit_b", 32'(hit_b_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode sweep: rt, rd, link, none, rd=0, bubble.
    push(5'd8, 3);  step(5'd8, 5'd9, 2'b00, 1, 1, 0, 0);
    chk("rt_s0", 32'(dst_o[4:0]), 8);
    push(5'd9, 3);  step(5'd8, 5'd9, 2'b01, 1, 1, 0, 0);
    chk("rd_s0", 32'(dst_o[4:0]), 9);
    push(5'd31, 3); step(5'd8, 5'd9, 2'b10, 1, 1, 0, 0);
    chk("ra_s0", 32'(dst_o[4:0]), 31);
    chk("sweep_we", 32'(we_o), 3'b111);
    step(5'd8, 5'd9, 2'b11, 1, 1, 0, 0);
    chk("none_we", 32'(we_o[0]), 0);
    step(5'd8, 5'd0, 2'b01, 1, 1, 0, 0);
    chk("rd0_we", 32'(we_o[0]), 0);
    step(5'd0, 5'd4, 2'b01, 1, 0, 0, 0);
    chk("bubble_we", 32'(we_o[0]), 0);
    idle(4);

    // Stall: 12 frozen for two cycles, arrives 5 cycles after issue.
    push(5'd12, 5); step(5'd0, 5'd12, 2'b01, 1, 1, 0, 0);
    chk("stall_pre_dst", 32'(dst_o), 12);
    step(5'd3, 5'd0, 2'b00, 1, 1, 1, 0);
    chk("stall1_dst", 32'(dst_o), 12);
    chk("stall1_we", 32'(we_o), 3'b001);
    step(5'd3, 5'd0, 2'b00, 1, 1, 1, 0);
    chk("stall2_dst", 32'(dst_o), 12);
    chk("stall2_we", 32'(we_o), 3'b001);
    idle(6);

    // Hazard: stage1 holds 10.
    push(5'd10, 3); step(5'd0, 5'd10, 2'b01, 1, 1, 0, 0);
    idle(1);
    src_a_i = 5'd10; src_b_i = 5'd0; #1;
    chk("hz_a", 32'(hit_a_o), 32'(HZ_S1));
    chk("hz_b0", 32'(hit_b_o), 0);
    src_b_i = 5'd10; #1;
    chk("hz_b", 32'(hit_b_o), 32'(HZ_S1));
    src_a_i = 5'd11; #1;
    chk("hz_a_miss", 32'(hit_a_o), 0);
    src_a_i = '0; src_b_i = '0;
    idle(4);

    // Flush with stall: stage0 cleared, stages 1..2 held; 21 and 7 lost.
    push(5'd20, 4); step(5'd0, 5'd20, 2'b01, 1, 1, 0, 0);
    step(5'd0, 5'd21, 2'b01, 1, 1, 0, 0);
    step(5'd0, 5'd7, 2'b01, 1, 1, 1, 1);
    chk("fs_dst", 32'(dst_o), 640);
    chk("fs_we", 32'(we_o), 3'b010);
    idle(5);

    // Flush alone: 22 shifts on, 7 killed.
    push(5'd22, 3); step(5'd0, 5'd22, 2'b01, 1, 1, 0, 0);
    step(5'd0, 5'd7, 2'b01, 1, 1, 0, 1);
    chk("fl_dst", 32'(dst_o), 704);
    chk("fl_we", 32'(we_o), 3'b010);
    idle(4);

    // Asynchronous reset mid-stream.
    step(5'd0, 5'd25, 2'b01, 1, 1, 0, 0);
    step(5'd0, 5'd26, 2'b01, 1, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dst", 32'(dst_o), 0);
    chk("arst_we", 32'(we_o), 0);
    chk("arst_wb_we", 32'(wb_we_o), 0);
    sb.delete();
    #2 rst_n = 1'b1;
    push(5'd9, 3); step(5'd0, 5'd9, 2'b01, 1, 1, 0, 0);
    chk("post_rst_dst", 32'(dst_o), 9);
    chk("post_rst_we", 32'(we_o), 3'b001);
    idle(6);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
